// File: rtl/mem_reader_pkg.sv
// Shared definitions for the memory range reader.
//  - DEPTH/AW/DW: memory geometry (DEPTH entries of DW bits, AW address bits)
//  - state_e:     reader FSM states
//  - beat_t:      one output beat (byte, its address, final-address flag)
// Optional feature macro: MEM_READER_SKIP_UNDEF_EN (see mem_range_reader.sv).
package mem_reader_pkg;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

endpackage

// File: rtl/mem_range_reader_if.sv
// Bus bundle of the memory range reader: command handshake, RAM read port,
// output beat stream and completion/status.
//  master: the reader (accepts commands, drives RAM reads, sources beats)
//  slave:  the environment (issues commands, RAM model, consumer)
interface mem_range_reader_if;
  import mem_reader_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_undef;
  logic          out_last;
  logic          done;
  logic [AW:0]   undef_cnt;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
    output cmd_ready, mem_ren, mem_raddr, out_valid, out_data, out_addr,
           out_undef, out_last, done, undef_cnt
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
    input  cmd_ready, mem_ren, mem_raddr, out_valid, out_data, out_addr,
           out_undef, out_last, done, undef_cnt
  );

endinterface

// File: rtl/mem_reader_skid.sv
// Two-entry valid/ready buffer of beat_t with a pass-through path when empty,
// so a beat can leave in the same cycle it arrives.
//  clk_i, rst_ni   clock, asynchronous active-low reset
//  in_valid_i/in_beat_i    incoming beat (always accepted; the producer's
//                          issue credit guarantees there is room)
//  out_valid_o/out_ready_i/out_beat_o  downstream handshake
//  occ_o           number of stored beats (0..2)
module mem_reader_skid
  import mem_reader_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  input  beat_t      in_beat_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output beat_t      out_beat_o,
  output logic [1:0] occ_o
);

  beat_t      mem_q [2];
  beat_t      mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       empty, push, pop_mem;

  assign empty       = (cnt_q == 2'd0);
  assign out_valid_o = !empty || in_valid_i;
  assign out_beat_o  = empty ? in_beat_i : mem_q[rd_ptr_q];
  // A beat consumed straight off the input is never stored.
  assign push        = in_valid_i && !(empty && out_ready_i);
  assign pop_mem     = !empty && out_ready_i;
  assign occ_o       = cnt_q;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_beat_i;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop_mem;
    cnt_d    = cnt_q + 2'(push) - 2'(pop_mem);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_range_reader.sv
// Walks an address range of a DEPTH x DW sync-read RAM and streams each byte
// out with its address; bit 0 of a byte marks it undefined and is counted.
//  clk, rst_n  clock, asynchronous active-low reset
//  bus         mem_range_reader_if.master: cmd_*, mem_*, out_*, done, undef_cnt
// Macro MEM_READER_SKIP_UNDEF_EN: undefined bytes are counted but not emitted.
module mem_range_reader
  import mem_reader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mem_range_reader_if.master  bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic          pend_last_q, pend_last_d;
  logic [AW:0]   undef_cnt_q, undef_cnt_d;

  logic       accept, issue, cap_valid, sk_valid;
  logic [1:0] occ, inflight;
  beat_t      cap_beat, sk_beat;

  assign bus.cmd_ready = (state_q == StIdle) && rst_n;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // At most two beats outstanding (in the RAM pipe or buffered).
  assign inflight  = {1'b0, pend_q} + occ;
  assign issue     = (state_q == StRun) && (inflight < 2'd2);
  assign bus.mem_ren   = issue;
  assign bus.mem_raddr = raddr_q;

`ifdef MEM_READER_SKIP_UNDEF_EN
  assign cap_valid = pend_q && !bus.mem_rdata[0];
`else
  assign cap_valid = pend_q;
`endif
  assign cap_beat = '{data: bus.mem_rdata, addr: pend_addr_q, last: pend_last_q};

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    rem_d       = rem_q;
    pend_d      = issue;
    pend_addr_d = pend_addr_q;
    pend_last_d = pend_last_q;
    undef_cnt_d = undef_cnt_q;

    if (issue) begin
      pend_addr_d = raddr_q;
      pend_last_d = (rem_q == (AW+1)'(1));
    end
    if (pend_q && bus.mem_rdata[0] && (undef_cnt_q != (AW+1)'(DEPTH))) begin
      undef_cnt_d = undef_cnt_q + (AW+1)'(1);
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          raddr_d     = bus.cmd_addr;
          rem_d       = bus.cmd_len;
          undef_cnt_d = '0;
          state_d     = (bus.cmd_len == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (issue) begin
          raddr_d = raddr_q + AW'(1);  // wraps modulo DEPTH
          rem_d   = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!pend_q && (occ == 2'd0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      raddr_q     <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_last_q <= 1'b0;
      undef_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_last_q <= pend_last_d;
      undef_cnt_q <= undef_cnt_d;
    end
  end

  mem_reader_skid u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (cap_valid),
    .in_beat_i   (cap_beat),
    .out_valid_o (sk_valid),
    .out_ready_i (bus.out_ready),
    .out_beat_o  (sk_beat),
    .occ_o       (occ)
  );

  assign bus.out_valid = sk_valid;
  assign bus.out_data  = sk_beat.data;
  assign bus.out_addr  = sk_beat.addr;
  assign bus.out_last  = sk_beat.last;
  assign bus.out_undef = sk_beat.data[0];
  // Drain completes only once nothing is in flight, so done never meets a handshake.
  assign bus.done      = (state_q == StDrain) && !pend_q && (occ == 2'd0);
  assign bus.undef_cnt = undef_cnt_q;

endmodule

// File: tb/tb_mem_range_reader.sv
// Directed bench for mem_range_reader: a RAM model, an expectation queue filled
// when each command is issued and drained as beats are accepted, plus latency,
// stall-stability, count and reset checks.
module tb_mem_range_reader;
  import mem_reader_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_range_reader_if bus ();

  mem_range_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_raddr];

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q [$];
  int          done_cyc, first_ren, first_valid, n_ren, n_hs, n_last, exp_total, exp_last;
  logic [AW:0] exp_undef;
  bit          prev_stall;
  beat_t       stall_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 0: all 8'hFE, 1: ram[i]=i, 2: odd 8'hFF / even 8'hFE
  task automatic fill(input int mode);
    for (int i = 0; i < int'(DEPTH); i++) begin
      case (mode)
        0:       ram[i] = 8'hFE;
        1:       ram[i] = 8'(i);
        default: ram[i] = (i % 2 == 1) ? 8'hFF : 8'hFE;
      endcase
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] addr, input logic [AW:0] len, input bit toggle);
    beat_t         cur, e;
    bit            got_done;
    logic [AW-1:0] a;
    exp_undef = '0;
    exp_total = 0;
    exp_last  = 0;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + AW'(i);
      if (ram[a][0]) exp_undef++;
`ifdef MEM_READER_SKIP_UNDEF_EN
      if (ram[a][0]) continue;
`endif
      exp_q.push_back('{data: ram[a], addr: a, last: (i == int'(len) - 1)});
      exp_total++;
      if (i == int'(len) - 1) exp_last++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    got_done = 1'b0; done_cyc = 0; first_ren = 0; first_valid = 0;
    n_ren = 0; n_hs = 0; n_last = 0; prev_stall = 1'b0;
    for (int cyc = 1; cyc <= 300 && !got_done; cyc++) begin
      bus.out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      cur = '{data: bus.out_data, addr: bus.out_addr, last: bus.out_last};
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_beat", 32'(cur), 32'(stall_beat));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      stall_beat = cur;
      if (bus.mem_ren) begin
        n_ren++;
        if (first_ren == 0) first_ren = cyc;
      end
      if (bus.out_valid && first_valid == 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        if (cur.last) n_last++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat", 32'(cur), 32'(e));
          chk("out_undef", 32'(bus.out_undef), 32'(e.data[0]));
        end
      end
      if (bus.done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("done_vs_handshake", 32'(bus.out_valid && bus.out_ready), 32'd0);
      end
      @(posedge clk); #1;
    end
    if (!got_done) chk("done_timeout", 32'(got_done), 32'd1);
    chk("beat_count", 32'(n_hs), 32'(exp_total));
    chk("last_count", 32'(n_last), 32'(exp_last));
    chk("queue_left", 32'(exp_q.size()), 32'd0);
    chk("undef_cnt", 32'(bus.undef_cnt), 32'(exp_undef));
    chk("ren_count", 32'(n_ren), 32'(len));
    exp_q.delete();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    fill(0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_mem_ren", 32'(bus.mem_ren), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_undef_cnt", 32'(bus.undef_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic range: latency and done timing.
    run_cmd(12'd0, 13'd4, 1'b0);
    chk("basic_first_ren", 32'(first_ren), 32'd1);
    chk("basic_first_valid", 32'(first_valid), 32'd2);
    chk("basic_done_cyc", 32'(done_cyc), 32'd6);

    // Wrap from DEPTH-1 to 0.
    run_cmd(12'd4094, 13'd4, 1'b0);

    // Empty command.
    run_cmd(12'd100, 13'd0, 1'b0);
    chk("len0_done_cyc", 32'(done_cyc), 32'd1);
    chk("len0_no_valid", 32'(first_valid), 32'd0);

    // Back-pressure with ascending data.
    fill(1);
    run_cmd(12'd0, 13'd8, 1'b1);

    // Alternating undefined entries.
    fill(2);
    run_cmd(12'd16, 13'd8, 1'b0);
    chk("undef_cnt_4", 32'(bus.undef_cnt), 32'd4);

    // Asynchronous reset in the middle of a full-depth command.
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 12'd0;
    bus.cmd_len   = 13'd4096;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_reset_undef_nonzero", 32'(bus.undef_cnt != '0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_mem_ren", 32'(bus.mem_ren), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("abort_undef_cnt", 32'(bus.undef_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill(0);
    run_cmd(12'd0, 13'd4, 1'b0);
    chk("after_abort_done_cyc", 32'(done_cyc), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
